seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
- REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
- REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit pattern[PAT_W-1] first; 0 = transmit pattern[0] first.
- REQ-003 clk, input, 1: the single clock; all state changes on the rising edge.
- REQ-004 rst, input, 1: reset, asynchronous and active-high.
- REQ-005 start, input, 1: request to transmit one frame; sampled on the rising edge of clk.
- REQ-006 pattern, input, PAT_W: frame bits; sampled on the same edge as an accepted start.
- REQ-007 out, output, 1: serial bit stream, the input stream for the team's Moore sequence detector.
- REQ-008 busy, output, 1: high while a frame is in progress, SEND through DONE.
- REQ-009 done, output, 1: single-cycle pulse marking the end of a frame.

Function
- REQ-010 Moore FSM with states IDLE, SEND, PAR and DONE; all outputs are decoded from registered state only, with no combinational path from any input to any output.
- REQ-011 IDLE: out=0, busy=0, done=0; start=1 at an edge -> SEND, pattern captured into a PAT_W-bit shift register and the bit counter cleared.
- REQ-012 Latency: the first pattern bit appears on out in the cycle after the edge that accepted start.
- REQ-013 SEND: out = current head bit of the shift register, busy=1; each edge shifts by one bit and increments the counter.
- REQ-014 SEND lasts exactly PAT_W cycles; after the last bit -> PAR when the parity feature is compiled in, else -> DONE.
- REQ-015 PAR: out = even-parity bit (XOR of all captured pattern bits), busy=1, for exactly one cycle -> DONE.
- REQ-016 DONE: out=0, busy=1, done=1 for exactly one cycle -> IDLE.
- REQ-017 start outside IDLE is ignored; it is not queued, and pattern changes mid-frame do not affect the frame in progress.
- REQ-018 start held high continuously yields back-to-back frames, each separated by exactly one IDLE cycle after DONE.
- REQ-019 Bit counter width is clog2(PAT_W+1); the counter never wraps within a frame.

Reset
- REQ-020 While rst=1, regardless of clk: state=IDLE, shift register=0, counter=0, out=0, busy=0, done=0.
- REQ-021 Reset asserted mid-frame aborts the frame immediately; no done pulse is produced for the aborted frame.
- REQ-022 After rst deasserts, the first rising edge may accept start.

Configuration
- REQ-023 Macro SEQ_GEN_PARITY_EN: when defined, the PAR state and parity bit are present, giving frame length PAT_W+1 bits.
- REQ-024 Without SEQ_GEN_PARITY_EN: PAR and the parity logic are absent, SEND goes directly to DONE, and frame length is PAT_W bits.

Structure
- REQ-025 Package seq_gen_pkg holds the 2-bit state encoding constants (IDLE=0, SEND=1, PAR=2, DONE=3); IDLE=0 is the reset state.
- REQ-026 Split into the sequential top seq_gen (state, shift and counter registers) and one combinational sub-module, seq_gen_combi, which computes next state and outputs.

Verification
- REQ-027 PAT_W=4, MSB_FIRST=1, no parity, pattern=4'b1011, start pulsed at edge 0 -> out=1,0,1,1 in cycles 1-4; done=1 in cycle 5; busy=1 in cycles 1-5.
- REQ-028 Same stimulus with SEQ_GEN_PARITY_EN defined -> out=1,0,1,1,1 in cycles 1-5 (parity=1); done=1 in cycle 6.
- REQ-029 MSB_FIRST=0, pattern=4'b0001 -> out=1,0,0,0 in cycles 1-4.
- REQ-030 start re-pulsed in cycle 2, with pattern changed to 4'b0000 -> frame 1011 completes unchanged and no second frame starts.
- REQ-031 rst asserted mid-cycle 3 -> out, busy and done are 0 at once without waiting for a clock edge; no done pulse; a new start after release produces a full frame.
- REQ-032 Loopback: seq_gen out drives the team's Moore detector input, with pattern set to the detector's target sequence -> the detector asserts its output once per frame.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared state encoding for the seq_gen serial frame generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_gen_combi.sv
// Next-state, datapath-update and output decode for seq_gen.
// SEQ_GEN_PARITY_EN adds the even-parity PAR state after the data bits.
module seq_gen_combi
    import seq_gen_pkg::*;
#(
    parameter int unsigned PAT_W     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CNT_W     = $clog2(PAT_W + 1)
) (
    input  logic [1:0]       state_i,
    input  logic [PAT_W-1:0] shift_i,
    input  logic [CNT_W-1:0] cnt_i,
`ifdef SEQ_GEN_PARITY_EN
    input  logic             par_i,
    output logic             par_o,
`endif
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic [1:0]       state_o,
    output logic [PAT_W-1:0] shift_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_W - 1);

    state_t cur_st;
    state_t nxt_st;
    logic   head;

    assign cur_st  = state_t'(state_i);
    assign state_o = nxt_st;

    always_comb begin : next_state
        nxt_st  = cur_st;
        shift_o = shift_i;
        cnt_o   = cnt_i;
`ifdef SEQ_GEN_PARITY_EN
        par_o   = par_i;
`endif
        case (cur_st)
            IDLE: begin
                if (start_i) begin
                    nxt_st  = SEND;
                    shift_o = pattern_i;
                    cnt_o   = '0;
`ifdef SEQ_GEN_PARITY_EN
                    par_o   = ^pattern_i;
`endif
                end
            end
            SEND: begin
                shift_o = (MSB_FIRST != 0) ? {shift_i[PAT_W-2:0], 1'b0}
                                           : {1'b0, shift_i[PAT_W-1:1]};
                cnt_o   = cnt_i + CNT_W'(1);
                if (cnt_i == LAST_CNT) begin
`ifdef SEQ_GEN_PARITY_EN
                    nxt_st = PAR;
`else
                    nxt_st = DONE;
`endif
                end
            end
            PAR: begin
`ifdef SEQ_GEN_PARITY_EN
                nxt_st = DONE;
`else
                nxt_st = IDLE;
`endif
            end
            DONE: nxt_st = IDLE;
        endcase
    end

    // Outputs decoded from the values the registers will hold after this edge.
    always_comb begin : output_decode
        out_o  = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        head   = (MSB_FIRST != 0) ? shift_o[PAT_W-1] : shift_o[0];
        case (nxt_st)
            SEND: begin
                out_o  = head;
                busy_o = 1'b1;
            end
            PAR: begin
`ifdef SEQ_GEN_PARITY_EN
                out_o  = par_o;
`endif
                busy_o = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_gen.sv
// Serial frame generator: shifts a captured pattern out one bit per cycle.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned PAT_W     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(PAT_W + 1);

    state_t           state_q;
    logic [1:0]       state_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_d, busy_d, done_d;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    seq_gen_combi #(
        .PAT_W     (PAT_W),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_combi (
        .state_i   (state_q),
        .shift_i   (shift_q),
        .cnt_i     (cnt_q),
`ifdef SEQ_GEN_PARITY_EN
        .par_i     (par_q),
        .par_o     (par_d),
`endif
        .start_i   (start),
        .pattern_i (pattern),
        .state_o   (state_d),
        .shift_o   (shift_d),
        .cnt_o     (cnt_d),
        .out_o     (out_d),
        .busy_o    (busy_d),
        .done_o    (done_d)
    );

    // All state and outputs clear immediately on reset, aborting any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_t'(state_d);
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out     <= out_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
